// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: fixed-priority grant of dcache / icache / prefetch onto one memory port,
// with prefetch anti-starvation and an owner table that routes returning tags to their issuer.
module mem_bus_arbiter #(
    parameter int SYS_XLEN     = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          dc_cmd,
    input  logic [SYS_XLEN-1:0] dc_addr,
    input  logic [63:0]         dc_data,
    input  logic [1:0]          ic_cmd,
    input  logic [SYS_XLEN-1:0] ic_addr,
    input  logic [1:0]          pf_cmd,
    input  logic [SYS_XLEN-1:0] pf_addr,
    input  logic                pf_squash,
    input  logic [3:0]          mem_response,
    input  logic [3:0]          mem_tag,
    input  logic [63:0]         mem_data,
    output logic [1:0]          mem_cmd,
    output logic [SYS_XLEN-1:0] mem_addr,
    output logic [63:0]         mem_wdata,
    output logic [3:0]          dc_response,
    output logic [3:0]          ic_response,
    output logic [3:0]          Imem2pref_response,
    output logic [3:0]          dc_tag,
    output logic [3:0]          ic_tag,
    output logic [3:0]          Imem2pref_tag,
    output logic [63:0]         rdata,
    output logic                pf_bus_priority,
    output logic                spurious_tag
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DC   = 2'd1,
        GNT_IC   = 2'd2,
        GNT_PF   = 2'd3
    } grant_e;

    localparam logic [1:0] OWN_DC = 2'd0;
    localparam logic [1:0] OWN_IC = 2'd1;
    localparam logic [1:0] OWN_PF = 2'd2;

    grant_e                w_grant;
    logic                  w_pf_starved;
    logic                  w_accept;
    logic [1:0]            w_owner_new;
    logic [1:0]            w_mem_cmd;
    logic [SYS_XLEN-1:0]   w_mem_addr;
    logic [63:0]           w_mem_wdata;
    logic [3:0]            w_dc_resp;
    logic [3:0]            w_ic_resp;
    logic [3:0]            w_pf_resp;
    logic [3:0]            w_dc_tag;
    logic [3:0]            w_ic_tag;
    logic [3:0]            w_pf_tag;
    logic                  w_ret_valid;
    logic [1:0]            w_ret_owner;
    logic                  w_ret_drop;
    logic                  w_spur_evt;

    logic [2:0]            r_starve_cnt;
    logic [NUM_TAGS-1:0]   r_valid;
    logic [NUM_TAGS-1:0]   r_drop;
    logic [1:0]            r_owner [NUM_TAGS];
    logic                  r_spurious;

    // Grant selection: dcache always wins; a starved prefetch jumps ahead of icache demand.
    always_comb begin
        w_pf_starved = (r_starve_cnt >= 3'(STARVE_LIMIT));
        if (dc_cmd != 2'd0) begin
            w_grant = GNT_DC;
        end else if ((pf_cmd != 2'd0) && w_pf_starved) begin
            w_grant = GNT_PF;
        end else if (ic_cmd != 2'd0) begin
            w_grant = GNT_IC;
        end else if (pf_cmd != 2'd0) begin
            w_grant = GNT_PF;
        end else begin
            w_grant = GNT_NONE;
        end
    end

    // Winner's command onto the memory port and accept tag back to the winner only.
    always_comb begin
        w_mem_cmd   = 2'd0;
        w_mem_addr  = '0;
        w_mem_wdata = 64'd0;
        w_dc_resp   = 4'd0;
        w_ic_resp   = 4'd0;
        w_pf_resp   = 4'd0;
        w_owner_new = OWN_DC;
        case (w_grant)
            GNT_DC: begin
                w_mem_cmd   = dc_cmd;
                w_mem_addr  = dc_addr;
                w_mem_wdata = dc_data;
                w_dc_resp   = mem_response;
                w_owner_new = OWN_DC;
            end
            GNT_IC: begin
                w_mem_cmd   = ic_cmd;
                w_mem_addr  = ic_addr;
                w_ic_resp   = mem_response;
                w_owner_new = OWN_IC;
            end
            GNT_PF: begin
                w_mem_cmd   = pf_cmd;
                w_mem_addr  = pf_addr;
                // A prefetch granted during a redirect still goes out, but its tag is hidden.
                w_pf_resp   = pf_squash ? 4'd0 : mem_response;
                w_owner_new = OWN_PF;
            end
            default: begin
                w_mem_cmd   = 2'd0;
            end
        endcase
        w_accept = (w_grant != GNT_NONE) && (mem_response != 4'd0);
    end

    // Return routing: look up the owner of the incoming tag.
    always_comb begin
        w_ret_valid = r_valid[mem_tag];
        w_ret_owner = r_owner[mem_tag];
        w_ret_drop  = r_drop[mem_tag];
        w_dc_tag    = 4'd0;
        w_ic_tag    = 4'd0;
        w_pf_tag    = 4'd0;
        w_spur_evt  = 1'b0;
        if (mem_tag != 4'd0) begin
            if (w_ret_valid) begin
                case (w_ret_owner)
                    OWN_DC:  w_dc_tag = mem_tag;
                    OWN_IC:  w_ic_tag = mem_tag;
                    OWN_PF:  w_pf_tag = w_ret_drop ? 4'd0 : mem_tag;
                    default: w_dc_tag = 4'd0;
                endcase
            end else begin
                w_spur_evt = 1'b1;
            end
        end else begin
            w_spur_evt = 1'b0;
        end
    end

    // Prefetch starvation counter, saturating at 7.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= 3'd0;
        end else if ((pf_cmd != 2'd0) && (w_grant != GNT_PF)) begin
            if (r_starve_cnt != 3'd7) begin
                r_starve_cnt <= r_starve_cnt + 3'd1;
            end
        end else begin
            r_starve_cnt <= 3'd0;
        end
    end

    // Owner table: squash marks, then return clear, then new accept (later assignment wins).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_drop  <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                r_owner[i] <= 2'd0;
            end
        end else begin
            for (int i = 1; i < NUM_TAGS; i++) begin
                if (pf_squash && r_valid[i] && (r_owner[i] == OWN_PF)) begin
                    r_drop[i] <= 1'b1;
                end
                if ((mem_tag == 4'(i)) && r_valid[i]) begin
                    r_valid[i] <= 1'b0;
                end
                if (w_accept && (mem_response == 4'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_owner[i] <= w_owner_new;
                    r_drop[i]  <= (w_grant == GNT_PF) && pf_squash;
                end
            end
        end
    end

    // Sticky flag for tags returning with no recorded owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_spurious <= 1'b0;
        end else if (w_spur_evt) begin
            r_spurious <= 1'b1;
        end
    end

    // Output stage: everything reads zero while reset is held.
    always_comb begin
        if (rst) begin
            mem_cmd            = w_mem_cmd;
            mem_addr           = w_mem_addr;
            mem_wdata          = w_mem_wdata;
            dc_response        = w_dc_resp;
            ic_response        = w_ic_resp;
            Imem2pref_response = w_pf_resp;
            dc_tag             = w_dc_tag;
            ic_tag             = w_ic_tag;
            Imem2pref_tag      = w_pf_tag;
            rdata              = mem_data;
            pf_bus_priority    = (w_grant == GNT_PF);
            spurious_tag       = r_spurious;
        end else begin
            mem_cmd            = 2'd0;
            mem_addr           = '0;
            mem_wdata          = 64'd0;
            dc_response        = 4'd0;
            ic_response        = 4'd0;
            Imem2pref_response = 4'd0;
            dc_tag             = 4'd0;
            ic_tag             = 4'd0;
            Imem2pref_tag      = 4'd0;
            rdata              = 64'd0;
            pf_bus_priority    = 1'b0;
            spurious_tag       = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: driver pushes hand-computed expected outputs per cycle,
// a separate monitor pops and compares them on the falling clock edge.
module tb_mem_bus_arbiter;

    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dc_cmd, ic_cmd, pf_cmd;
    logic [31:0] dc_addr, ic_addr, pf_addr;
    logic [63:0] dc_data, mem_data;
    logic        pf_squash;
    logic [3:0]  mem_response, mem_tag;
    logic [1:0]  mem_cmd;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, rdata;
    logic [3:0]  dc_response, ic_response, Imem2pref_response;
    logic [3:0]  dc_tag, ic_tag, Imem2pref_tag;
    logic        pf_bus_priority, spurious_tag;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.SYS_XLEN(32), .STARVE_LIMIT(4), .NUM_TAGS(16)) dut (
        .clk(clk), .rst(rst),
        .dc_cmd(dc_cmd), .dc_addr(dc_addr), .dc_data(dc_data),
        .ic_cmd(ic_cmd), .ic_addr(ic_addr),
        .pf_cmd(pf_cmd), .pf_addr(pf_addr), .pf_squash(pf_squash),
        .mem_response(mem_response), .mem_tag(mem_tag), .mem_data(mem_data),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .dc_response(dc_response), .ic_response(ic_response),
        .Imem2pref_response(Imem2pref_response),
        .dc_tag(dc_tag), .ic_tag(ic_tag), .Imem2pref_tag(Imem2pref_tag),
        .rdata(rdata), .pf_bus_priority(pf_bus_priority), .spurious_tag(spurious_tag)
    );

    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [3:0]  dcr, icr, pfr, dct, ict, pft;
        logic [63:0] rdata;
        logic        prio;
        logic        spur;
    } outv_t;

    outv_t exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    outv_t m_exp, m_act;
    string m_nm;

    task automatic expect_out(input string nm, input logic [1:0] cmd, input logic [31:0] addr,
                              input logic [63:0] wd, input logic [3:0] dcr, input logic [3:0] icr,
                              input logic [3:0] pfr, input logic [3:0] dct, input logic [3:0] ict,
                              input logic [3:0] pft, input logic [63:0] rd, input logic prio,
                              input logic spur);
        outv_t e;
        e.cmd = cmd; e.addr = addr; e.wdata = wd;
        e.dcr = dcr; e.icr = icr; e.pfr = pfr;
        e.dct = dct; e.ict = ict; e.pft = pft;
        e.rdata = rd; e.prio = prio; e.spur = spur;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic expect_quiet(input string nm, input logic spur);
        expect_out(nm, 2'd0, 32'd0, 64'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 64'd0, 1'b0, spur);
    endtask

    task automatic idle();
        dc_cmd = 2'd0; dc_addr = 32'd0; dc_data = 64'd0;
        ic_cmd = 2'd0; ic_addr = 32'd0;
        pf_cmd = 2'd0; pf_addr = 32'd0; pf_squash = 1'b0;
        mem_response = 4'd0; mem_tag = 4'd0; mem_data = 64'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Monitor: compare every cycle that has a pending expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                m_exp = exp_q.pop_front();
                m_nm  = name_q.pop_front();
                m_act = {mem_cmd, mem_addr, mem_wdata, dc_response, ic_response,
                         Imem2pref_response, dc_tag, ic_tag, Imem2pref_tag, rdata,
                         pf_bus_priority, spurious_tag};
                checks++;
                if (m_act !== m_exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", m_nm, m_act, m_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        idle();
        @(posedge clk);
        #1;
        // Held in reset with live requests: every output must be zero.
        dc_cmd = LOAD; dc_addr = 32'h100; mem_response = 4'd3; mem_tag = 4'd5;
        mem_data = 64'h1111_2222_3333_4444;
        expect_quiet("reset_outputs", 1'b0);

        step(); rst = 1'b1;
        dc_cmd = LOAD; dc_addr = 32'h100; ic_cmd = LOAD; ic_addr = 32'h200;
        pf_cmd = LOAD; pf_addr = 32'h300; mem_response = 4'd3;
        expect_out("prio_dc", LOAD, 32'h100, 64'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 64'd0, 1'b0, 1'b0);

        step(); mem_tag = 4'd3; mem_data = 64'hA5A5_0000_0000_0003;
        expect_out("ret_dc", 2'd0, 32'd0, 64'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0,
                   64'hA5A5_0000_0000_0003, 1'b0, 1'b0);

        step(); dc_cmd = STORE; dc_addr = 32'h180; dc_data = 64'hDEAD_BEEF_0123_4567; mem_response = 4'd4;
        expect_out("store", STORE, 32'h180, 64'hDEAD_BEEF_0123_4567, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                   64'd0, 1'b0, 1'b0);

        // Store tag returns while icache is accepted on the very same tag.
        step(); mem_tag = 4'd4; ic_cmd = LOAD; ic_addr = 32'h240; mem_response = 4'd4;
        expect_out("reuse_same_cycle", LOAD, 32'h240, 64'd0, 4'd0, 4'd4, 4'd0, 4'd4, 4'd0, 4'd0,
                   64'd0, 1'b0, 1'b0);
        step(); mem_tag = 4'd4;
        expect_out("reuse_ret_ic", 2'd0, 32'd0, 64'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd0, 64'd0, 1'b0, 1'b0);

        // Starvation: icache wins four times, then prefetch is promoted once.
        for (int c = 0; c < 6; c++) begin
            step(); ic_cmd = LOAD; ic_addr = 32'h200; pf_cmd = LOAD; pf_addr = 32'h300;
            if (c == 4)
                expect_out($sformatf("starve_c%0d", c), LOAD, 32'h300, 64'd0, 4'd0, 4'd0, 4'd0,
                           4'd0, 4'd0, 4'd0, 64'd0, 1'b1, 1'b0);
            else
                expect_out($sformatf("starve_c%0d", c), LOAD, 32'h200, 64'd0, 4'd0, 4'd0, 4'd0,
                           4'd0, 4'd0, 4'd0, 64'd0, 1'b0, 1'b0);
        end

        step(); pf_cmd = LOAD; pf_addr = 32'h310; mem_response = 4'd5;
        expect_out("pf_acc5", LOAD, 32'h310, 64'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 64'd0, 1'b1, 1'b0);
        step(); ic_cmd = LOAD; ic_addr = 32'h210; mem_response = 4'd6;
        expect_out("ic_acc6", LOAD, 32'h210, 64'd0, 4'd0, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 64'd0, 1'b0, 1'b0);
        step(); mem_tag = 4'd6;
        expect_out("ret_ic6", 2'd0, 32'd0, 64'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd6, 4'd0, 64'd0, 1'b0, 1'b0);
        step(); mem_tag = 4'd5;
        expect_out("ret_pf5", 2'd0, 32'd0, 64'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 64'd0, 1'b0, 1'b0);

        // Squash: outstanding and same-cycle prefetch tags vanish, icache tags survive.
        step(); pf_cmd = LOAD; pf_addr = 32'h340; mem_response = 4'd7;
        expect_out("pf_acc7", LOAD, 32'h340, 64'd0, 4'd0, 4'd0, 4'd7, 4'd0, 4'd0, 4'd0, 64'd0, 1'b1, 1'b0);
        step(); ic_cmd = LOAD; ic_addr = 32'h250; mem_response = 4'd10;
        expect_out("ic_acc10", LOAD, 32'h250, 64'd0, 4'd0, 4'd10, 4'd0, 4'd0, 4'd0, 4'd0, 64'd0, 1'b0, 1'b0);
        step(); pf_squash = 1'b1;
        expect_quiet("squash_pulse", 1'b0);
        step(); pf_cmd = LOAD; pf_addr = 32'h380; mem_response = 4'd8; pf_squash = 1'b1;
        expect_out("pf_acc8_squash", LOAD, 32'h380, 64'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 64'd0, 1'b1, 1'b0);
        step(); mem_tag = 4'd10;
        expect_out("ret_ic10", 2'd0, 32'd0, 64'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd10, 4'd0, 64'd0, 1'b0, 1'b0);
        step(); mem_tag = 4'd7;
        expect_quiet("ret_pf7_dropped", 1'b0);
        step(); mem_tag = 4'd8;
        expect_quiet("ret_pf8_dropped", 1'b0);
        step();
        expect_quiet("no_spur_after_drop", 1'b0);

        // Entry 7 was cleared by its dropped return; a repeat is spurious, as is tag 9.
        step(); mem_tag = 4'd7;
        expect_quiet("ret7_again", 1'b0);
        step(); mem_tag = 4'd9;
        expect_quiet("ret9_spur", 1'b1);
        step();
        expect_quiet("spur_sticky", 1'b1);

        step(); rst = 1'b0; dc_cmd = LOAD; dc_addr = 32'h500; mem_tag = 4'd9; mem_data = 64'h77;
        expect_quiet("reset_clears_spur", 1'b0);
        step(); rst = 1'b1; dc_cmd = LOAD; dc_addr = 32'h140; mem_response = 4'd2;
        expect_out("dc_acc2", LOAD, 32'h140, 64'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 64'd0, 1'b0, 1'b0);
        step(); rst = 1'b0;
        expect_quiet("async_reset_midflight", 1'b0);
        step(); rst = 1'b1; mem_tag = 4'd2;
        expect_quiet("ret2_after_reset", 1'b0);
        step();
        expect_quiet("ret2_spur_flag", 1'b1);

        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
